posit_encode_pipe: RTL and testbench

- Posit encoder for a decoded `value_sum` result: normalizes the fraction, builds regime/exponent/fraction fields, rounds to nearest-even and emits a 32-bit posit word (NBITS=32, ES=3).
- It is the write-back end of the posit datapath and the inverse of the posit decoder that produces `value` structs. It sits after the posit accumulator in the PairHMM pipeline.
- 3-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/posit_encode_pipe.sv | 136 +++++++++++++
 tb/tb_posit_encode_pipe.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: 3-stage posit encoder turning a decoded value_sum into a 32-bit posit word.
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   input sum valid
//   in_ready   stage 1 can take a new sum this cycle
//   in_data    value_sum {sign, scale, fraction, inf, zero}, hidden bit at fraction[ABITS-1]
//   out_valid  encoded posit valid
//   out_ready  consumer accepts the posit
//   out_posit  encoded posit (NBITS wide)
package posit_defines;
    localparam int NBITS = 32;
    localparam int ES    = 3;
    localparam int FBITS = 26;
    localparam int ABITS = FBITS + 4;
    typedef struct packed {
        logic              sign;
        logic signed [8:0] scale;
        logic [ABITS-1:0]  fraction;
        logic              inf;
        logic              zero;
    } value_sum;
endpackage

module posit_encode_pipe
    import posit_defines::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  value_sum         in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_posit
);
    // Shifter width: 2-bit regime seed, exponent, fraction below the hidden bit,
    // plus NBITS-2 zero pad so the longest regime run never loses dropped bits.
    localparam int BW = ES + ABITS + NBITS - 1;
    localparam logic [NBITS-1:0] MAXPOS = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0] NAR    = {1'b1, {(NBITS-1){1'b0}}};

    logic                    w_en1, w_en2, w_en3;
    logic [4:0]              w_lz;
    logic [ABITS-1:0]        w_norm;
    logic signed [10:0]      w_scale1;
    logic                    r1_v, r1_sign, r1_inf, r1_zero;
    logic signed [10:0]      r1_scale;
    logic [ABITS-2:0]        r1_frac;
    logic signed [10:0]      w_k;
    logic [10:0]             w_kabs;
    logic signed [BW-1:0]    w_base;
    logic [BW-1:0]           w_bits;
    logic                    r2_v, r2_sign, r2_inf, r2_zero, r2_smax, r2_smin;
    logic [BW-1:0]           r2_bits;
    logic                    w_rnd;
    logic [NBITS-1:0]        w_sum, w_mag, w_res;
    logic                    r3_v;
    logic [NBITS-1:0]        r3_posit;

    // A stage loads when empty or when its contents move on this cycle.
    assign w_en3     = !r3_v || out_ready;
    assign w_en2     = !r2_v || w_en3;
    assign w_en1     = !r1_v || w_en2;
    assign in_ready  = w_en1;
    assign out_valid = r3_v;
    assign out_posit = r3_posit;

    // S1: leading-zero count, highest set bit wins.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < ABITS; i++)
            if (in_data.fraction[i]) w_lz = 5'(ABITS - 1 - i);
    end

    assign w_norm   = in_data.fraction << w_lz;
    assign w_scale1 = {{2{in_data.scale[8]}}, in_data.scale} - {6'd0, w_lz};

    // S2: regime built by arithmetic-shifting a "10" (k>=0) or "01" (k<0) seed;
    // the shift replicates the seed's MSB, giving k+1 ones or -k zeros.
    assign w_k    = r1_scale >>> ES;
    assign w_kabs = w_k[10] ? ~w_k : w_k;
    assign w_base = {w_k[10] ? 2'b01 : 2'b10, r1_scale[ES-1:0], r1_frac, {(NBITS-2){1'b0}}};
    assign w_bits = w_base >>> w_kabs;

    // S3: round to nearest even on the NBITS-1 magnitude bits.
    assign w_rnd = r2_bits[BW-NBITS] & (r2_bits[BW-NBITS+1] | (|r2_bits[BW-NBITS-1:0]));
    assign w_sum = {1'b0, r2_bits[BW-1 -: NBITS-1]} + NBITS'(w_rnd);
    assign w_mag = (r2_smax || w_sum[NBITS-1]) ? MAXPOS :
                   (r2_smin || w_sum == '0)    ? NBITS'(1) : w_sum;
    assign w_res = r2_inf  ? NAR :
                   r2_zero ? '0  :
                   r2_sign ? -w_mag : w_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_v     <= 1'b0;
            r1_sign  <= 1'b0;
            r1_inf   <= 1'b0;
            r1_zero  <= 1'b0;
            r1_scale <= '0;
            r1_frac  <= '0;
            r2_v     <= 1'b0;
            r2_sign  <= 1'b0;
            r2_inf   <= 1'b0;
            r2_zero  <= 1'b0;
            r2_smax  <= 1'b0;
            r2_smin  <= 1'b0;
            r2_bits  <= '0;
            r3_v     <= 1'b0;
            r3_posit <= '0;
        end else begin
            if (w_en1) begin
                r1_v     <= in_valid;
                r1_sign  <= in_data.sign;
                r1_inf   <= in_data.inf;
                // After normalization the hidden bit is clear only for a zero fraction.
                r1_zero  <= in_data.zero || !w_norm[ABITS-1];
                r1_scale <= w_scale1;
                r1_frac  <= w_norm[ABITS-2:0];
            end
            if (w_en2) begin
                r2_v    <= r1_v;
                r2_sign <= r1_sign;
                r2_inf  <= r1_inf;
                r2_zero <= r1_zero;
                r2_smax <= r1_scale > 11'sd240;
                r2_smin <= r1_scale < -11'sd240;
                r2_bits <= w_bits;
            end
            if (w_en3) begin
                r3_v     <= r2_v;
                r3_posit <= w_res;
            end
        end
    end
endmodule

// File: tb/tb_posit_encode_pipe.sv
// tb_posit_encode_pipe: directed-vector bench for posit_encode_pipe (encoding, rounding, specials,
// backpressure and mid-stream reset), expected words computed by hand.
module tb_posit_encode_pipe;
    import posit_defines::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    value_sum    in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_posit;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    posit_encode_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic value_sum mk(input logic s, input int sc, input logic [29:0] f,
                                    input logic inf, input logic z);
        value_sum v;
        v.sign     = s;
        v.scale    = sc[8:0];
        v.fraction = f;
        v.inf      = inf;
        v.zero     = z;
        return v;
    endfunction

    // Accept edge, then two more edges: out_valid must appear exactly then.
    task automatic send_one(input string tag, input value_sum d, input logic [31:0] exp);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk(tag, out_posit, exp);
    endtask

    value_sum    bp_in[6];
    logic [31:0] bp_exp[6];

    initial begin
        int          idx, oidx, seen;
        logic        stalled;
        logic [31:0] held;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_posit", out_posit, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);

        send_one("one",       mk(0,    0, 30'h20000000, 0, 0), 32'h40000000);
        send_one("neg_one",   mk(1,    0, 30'h20000000, 0, 0), 32'hC0000000);
        send_one("scale1",    mk(0,    1, 30'h20000000, 0, 0), 32'h44000000);
        send_one("scale8",    mk(0,    8, 30'h20000000, 0, 0), 32'h60000000);
        send_one("scale_m1",  mk(0,   -1, 30'h20000000, 0, 0), 32'h3C000000);
        send_one("neg_m8",    mk(1,   -8, 30'h20000000, 0, 0), 32'hE0000000);
        send_one("norm",      mk(0,    2, 30'h08000000, 0, 0), 32'h40000000);
        send_one("frac0",     mk(0,    5, 30'h00000000, 0, 0), 32'h00000000);
        send_one("tie_even",  mk(0,    0, 30'h20000004, 0, 0), 32'h40000000);
        send_one("tie_odd",   mk(0,    0, 30'h2000000C, 0, 0), 32'h40000002);
        send_one("above",     mk(0,    0, 30'h20000005, 0, 0), 32'h40000001);
        send_one("ripple",    mk(0,    7, 30'h3FFFFFFF, 0, 0), 32'h60000000);
        send_one("max240",    mk(0,  240, 30'h20000000, 0, 0), 32'h7FFFFFFF);
        send_one("min240",    mk(0, -240, 30'h20000000, 0, 0), 32'h00000001);
        send_one("sat_max",   mk(0,  250, 30'h20000000, 0, 0), 32'h7FFFFFFF);
        send_one("sat_min",   mk(0, -250, 30'h20000000, 0, 0), 32'h00000001);
        send_one("nsat_max",  mk(1,  250, 30'h20000000, 0, 0), 32'h80000001);
        send_one("nsat_min",  mk(1, -250, 30'h20000000, 0, 0), 32'hFFFFFFFF);
        send_one("zero_neg",  mk(1,    3, 30'h20000000, 0, 1), 32'h00000000);
        send_one("inf_zero",  mk(1,    0, 30'h20000000, 1, 1), 32'h80000000);

        for (int i = 0; i < 6; i++) begin
            bp_in[i]  = mk(0, i, 30'h20000000, 0, 0);
            bp_exp[i] = 32'h40000000 | (32'(i) << 26);
        end
        idx = 0;
        oidx = 0;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 40 && oidx < 6; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid  = (idx < 6);
            in_data   = bp_in[idx < 6 ? idx : 5];
            #1;
            if (c == 3) begin
                chk("bp_ready_drop", {31'b0, in_ready}, 32'd0);
                chk("bp_accepted", idx, 32'd3);
            end
            if (out_valid && !out_ready) begin
                if (stalled) chk("bp_stable", out_posit, held);
                held = out_posit;
                stalled = 1'b1;
            end else stalled = 1'b0;
            if (out_valid && out_ready) begin
                chk("bp_order", out_posit, bp_exp[oidx]);
                oidx++;
            end
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_count", oidx, 32'd6);

        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(0, 1, 30'h20000000, 0, 0);
        @(negedge clk);
        in_data   = mk(0, 2, 30'h20000000, 0, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        @(negedge clk);
        chk("mid_pre_valid", {31'b0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_posit", out_posit, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_stale", seen, 32'd0);
        send_one("mid_next", mk(0, 8, 30'h20000000, 0, 0), 32'h60000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
